lvds_tx_framer: RTL

Parametrised LVDS panel framer: generates raster timing (H/V counters, DE, HSYNC, VSYNC), requests pixels by x/y, and packs 1 or 2 pixel channels of 6- or 8-bit colour plus a clock lane into 7-bit-per-lane words for the downstream 7:1 serialiser gearbox. It is the generalised successor of the fixed 960x1200 dual-channel 18-bit framer. It adds a start/stop state machine, programmable sync polarity, and a pipelined pixel-fetch latency.

---
 rtl/lvds_tx_framer_if.sv | 33 +++
 rtl/lvds_tx_framer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lvds_tx_framer_if.sv
// lvds_tx_framer_if: enable/colour/pattern inputs and raster/word outputs of the LVDS framer.
// i_pattern only exists when LVDS_TX_FRAMER_PATTERN_EN is defined.
interface lvds_tx_framer_if #(
  parameter int CHANNELS   = 2,
  parameter int COLOR_BITS = 6
);
  localparam int LANES = COLOR_BITS == 8 ? 4 : 3;
  logic                            i_enable;
  logic [24*CHANNELS-1:0]          i_color;
`ifdef LVDS_TX_FRAMER_PATTERN_EN
  logic                            i_pattern;
`endif
  logic [11:0]                     o_x;
  logic [11:0]                     o_y;
  logic                            o_req;
  logic                            o_frame_start;
  logic                            o_busy;
  logic [7*(LANES*CHANNELS+1)-1:0] o_word;
  modport master (
    input  i_enable, i_color,
`ifdef LVDS_TX_FRAMER_PATTERN_EN
    input  i_pattern,
`endif
    output o_x, o_y, o_req, o_frame_start, o_busy, o_word
  );
  modport slave (
    output i_enable, i_color,
`ifdef LVDS_TX_FRAMER_PATTERN_EN
    output i_pattern,
`endif
    input  o_x, o_y, o_req, o_frame_start, o_busy, o_word
  );
endinterface

// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: raster timing, pixel fetch and 7-bit-per-lane packing for a 7:1 LVDS gearbox.
// LVDS_TX_FRAMER_PATTERN_EN adds i_pattern, which swaps pixel colour for 8 vertical colour bars.
module lvds_tx_framer #(
  parameter int H_ACTIVE      = 960,
  parameter int H_FP          = 24,
  parameter int H_SYNC        = 16,
  parameter int H_BP          = 40,
  parameter int V_ACTIVE      = 1200,
  parameter int V_FP          = 3,
  parameter int V_SYNC        = 6,
  parameter int V_BP          = 26,
  parameter bit HS_POL        = 1'b0,
  parameter bit VS_POL        = 1'b0,
  parameter int CHANNELS      = 2,
  parameter int COLOR_BITS    = 6,
  parameter int FETCH_LATENCY = 2
) (
  input logic             i_clk,
  input logic             i_reset,
  lvds_tx_framer_if.master bus
);
  localparam int LANES = COLOR_BITS == 8 ? 4 : 3;
  localparam int WW    = 7*(LANES*CHANNELS+1);
  localparam int L     = FETCH_LATENCY;
  localparam logic [11:0] HLAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VLAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS0   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                 state_q, state_d;
  logic [11:0]            h_q, h_d, v_q, v_d, x_q, y_q;
  logic                   req_q, fs_q, hs_q, vs_q;
  logic                   act_q, act_d, de_d, hlast, last;
  logic [L-1:0]           de_p_q, hs_p_q, vs_p_q;
  logic [24*CHANNELS-1:0] col_a;
  logic [WW-1:0]          word_q;

  // Colour is zeroed outside DE; syncs leave at their configured active level.
  function automatic logic [WW-1:0] pack(input logic de, input logic hs, input logic vs,
                                         input logic [24*CHANNELS-1:0] col);
    logic [WW-1:0] w;
    logic [7:0]    r, g, b;
    logic [5:0]    r6, g6, b6;
    logic [27:0]   cw;
    w      = '0;
    w[6:0] = 7'b1100011;
    for (int c = 0; c < CHANNELS; c++) begin
      {r, g, b} = de ? col[24*c +: 24] : 24'h0;
      r6 = COLOR_BITS == 8 ? r[5:0] : r[7:2];
      g6 = COLOR_BITS == 8 ? g[5:0] : g[7:2];
      b6 = COLOR_BITS == 8 ? b[5:0] : b[7:2];
      cw = {1'b0, b[7:6], g[7:6], r[7:6],
            de, VS_POL ? vs : !vs, HS_POL ? hs : !hs, b6[5:2],
            b6[1:0], g6[5:1],
            g6[0], r6};
      w[7*(1+c*LANES) +: 7*LANES] = cw[7*LANES-1:0];
    end
    return w;
  endfunction

  always_comb begin
    act_q   = state_q != IDLE;
    hlast   = h_q == HLAST;
    last    = hlast && v_q == VLAST;
    state_d = bus.i_enable ? RUN : (state_q == IDLE || (state_q == STOP && last)) ? IDLE : STOP;
    h_d     = (!act_q || hlast) ? '0 : h_q + 12'd1;
    v_d     = !act_q ? '0 : !hlast ? v_q : (v_q == VLAST) ? '0 : v_q + 12'd1;
    act_d   = state_d != IDLE;
    de_d    = act_d && h_d < HA && v_d < VA;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= de_d ? h_d : '0;
      y_q     <= de_d ? v_d : '0;
      req_q   <= de_d;
      fs_q    <= act_d && h_d == '0 && v_d == '0;
      hs_q    <= act_d && h_d >= HS0 && h_d < HS1;
      vs_q    <= act_d && v_d >= VS0 && v_d < VS1;
    end
  end

`ifdef LVDS_TX_FRAMER_PATTERN_EN
  logic [11:0] x_p_q [L];
  logic [2:0]  bar;
  assign bar   = 3'(({3'b0, x_p_q[L-1]} << 3) / 15'(H_ACTIVE));
  assign col_a = bus.i_pattern ? {CHANNELS{{8{!bar[1]}}, {8{!bar[2]}}, {8{!bar[0]}}}} : bus.i_color;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < L; i++) x_p_q[i] <= '0;
    end else begin
      x_p_q[0] <= x_q;
      for (int i = 1; i < L; i++) x_p_q[i] <= x_p_q[i-1];
    end
  end
`else
  assign col_a = bus.i_color;
`endif

  // Internal sync flags are active-high; polarity is applied only when packing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      de_p_q <= '0;
      hs_p_q <= '0;
      vs_p_q <= '0;
      word_q <= pack(1'b0, 1'b0, 1'b0, '0);
    end else begin
      de_p_q <= L'({de_p_q, req_q});
      hs_p_q <= L'({hs_p_q, hs_q});
      vs_p_q <= L'({vs_p_q, vs_q});
      word_q <= pack(de_p_q[L-1], hs_p_q[L-1], vs_p_q[L-1], col_a);
    end
  end

  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_req         = req_q;
  assign bus.o_frame_start = fs_q;
  assign bus.o_busy        = state_q != IDLE;
  assign bus.o_word        = word_q;
endmodule
